data_mem_interface: RTL and testbench

Memory-stage access unit between the EX/MEM pipeline register and the MEM/WB register. Converts the M-stage control bundle (MemRead/MemWrite, byte/half, sign-extend, Left/Right, LL/SC, ReverseEndian, KernelMode) into aligned requests on the data-memory port. Runs a request/ready handshake and stalls the pipeline while an access is outstanding. Returns the load/SC result and reports address errors.

---
 rtl/data_mem_interface_pkg.sv | 28 ++
 rtl/data_mem_interface_if.sv | 19 +
 rtl/data_mem_interface_load_store_align.sv | 63 ++++++
 rtl/data_mem_interface.sv | 156 +++++++++++++++
 tb/tb_data_mem_interface.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_interface_pkg.sv
// Shared types for the memory-stage access unit: FSM states, byte-enable
// constants, address-error kinds and the lane-offset helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_ALL     = 4'b1111;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;

  typedef enum logic [1:0] {
    AE_NONE      = 2'd0,
    AE_MISALIGN  = 2'd1,
    AE_USER_KSEG = 2'd2
  } adr_err_t;

  // Big-endian lane index; reverse-endian mode mirrors it within the word.
  function automatic logic [1:0] lane_offset(input logic [1:0] i_addr, input logic i_rev);
    return i_addr ^ {2{i_rev}};
  endfunction

endpackage

// File: rtl/data_mem_interface_if.sv
// Data-memory port bundle: the pipeline side is master, the memory is slave.
interface data_mem_interface_if;
  logic        DataMem_Read;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] DataMem_Out;
  logic [31:0] DataMem_In;
  logic        DataMem_Ready;

  modport master (
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    input  DataMem_In, DataMem_Ready
  );

  modport slave (
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out,
    output DataMem_In, DataMem_Ready
  );
endinterface

// File: rtl/data_mem_interface_load_store_align.sv
// Combinational lane steering: store data/byte enables and load extract/merge
// for byte, half, word and the unaligned left/right forms.
module load_store_align
  import mips_mem_pkg::*;
(
  input  logic        i_byte,
  input  logic        i_half,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_sign_ext,
  input  logic [1:0]  i_k,
  input  logic [31:0] i_rt,
  input  logic [31:0] i_mem,
  output logic [31:0] o_store_dat,
  output logic [3:0]  o_store_we,
  output logic [31:0] o_load_dat
);

  logic [4:0]  w_sh_k;
  logic [4:0]  w_sh_rk;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // ~k is 3-k for a two-bit lane index
  assign w_sh_k  = {i_k, 3'b000};
  assign w_sh_rk = {~i_k, 3'b000};

  always_comb begin
    w_byte      = 8'(i_mem >> w_sh_rk);
    w_half      = i_k[1] ? i_mem[15:0] : i_mem[31:16];
    o_store_dat = i_rt;
    o_store_we  = BE_ALL;
    o_load_dat  = i_mem;
    if (i_left) begin
      o_store_dat = i_rt >> w_sh_k;
      o_store_we  = BE_ALL >> i_k;
      case (i_k)
        2'd0:    o_load_dat = i_mem;
        2'd1:    o_load_dat = {i_mem[23:0], i_rt[7:0]};
        2'd2:    o_load_dat = {i_mem[15:0], i_rt[15:0]};
        default: o_load_dat = {i_mem[7:0], i_rt[23:0]};
      endcase
    end else if (i_right) begin
      o_store_dat = i_rt << w_sh_rk;
      o_store_we  = BE_ALL << (~i_k);
      case (i_k)
        2'd0:    o_load_dat = {i_rt[31:8], i_mem[31:24]};
        2'd1:    o_load_dat = {i_rt[31:16], i_mem[31:16]};
        2'd2:    o_load_dat = {i_rt[31:24], i_mem[31:8]};
        default: o_load_dat = i_mem;
      endcase
    end else if (i_byte) begin
      o_store_dat = {4{i_rt[7:0]}};
      o_store_we  = BE_BYTE0 >> i_k;
      o_load_dat  = {{24{i_sign_ext & w_byte[7]}}, w_byte};
    end else if (i_half) begin
      o_store_dat = {2{i_rt[15:0]}};
      o_store_we  = i_k[1] ? BE_HALF_LO : BE_HALF_HI;
      o_load_dat  = {{16{i_sign_ext & w_half[15]}}, w_half};
    end
  end

endmodule

// File: rtl/data_mem_interface.sv
// Memory-stage access unit: address checks, LL/SC tracking, request/ready FSM
// with pipeline stall and a hold latch for results that arrive while M is stalled.
module data_mem_interface
  import mips_mem_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 M_MemRead,
  input  logic                 M_MemWrite,
  input  logic                 M_MemByte,
  input  logic                 M_MemHalf,
  input  logic                 M_MemSignExtend,
  input  logic                 M_Left,
  input  logic                 M_Right,
  input  logic                 M_LLSC,
  input  logic                 M_ReverseEndian,
  input  logic                 M_KernelMode,
  input  logic [31:0]          M_ALU_Result,
  input  logic [31:0]          M_ReadData2,
  input  logic                 M_Flush,
  input  logic                 Pipe_Stall,
  input  logic                 Eret,
  data_mem_interface_if.master dmem,
  output logic [31:0]          M_ReadData,
  output logic                 M_Stall,
  output logic                 M_EXC_AdEL,
  output logic                 M_EXC_AdES
);

  mem_state_t  r_state;
  logic        r_rd;
  logic [3:0]  r_we;
  logic        r_flushed;
  logic        r_atomic;
  logic [29:0] r_lladdr;
  logic [31:0] r_latch;

  logic [1:0]  w_k;
  adr_err_t    w_err;
  logic        w_access, w_ll, w_sc, w_sc_ok, w_issue, w_sc_fail;
  logic        w_rd, w_req, w_done, w_discard;
  logic [3:0]  w_we, w_st_we;
  logic [31:0] w_st_dat, w_ld_dat, w_result;

  assign w_k      = lane_offset(M_ALU_Result[1:0], M_ReverseEndian);
  assign w_access = M_MemRead | M_MemWrite;
  assign w_ll     = M_LLSC & M_MemRead;
  assign w_sc     = M_LLSC & M_MemWrite;
  assign w_sc_ok  = r_atomic && (r_lladdr == M_ALU_Result[31:2]);

  always_comb begin
    w_err = AE_NONE;
    if (w_access) begin
      if (!M_KernelMode && M_ALU_Result[31])
        w_err = AE_USER_KSEG;
      else if (!(M_Left || M_Right) &&
               ((M_MemHalf && M_ALU_Result[0]) ||
                (!M_MemHalf && !M_MemByte && (M_ALU_Result[1:0] != 2'b00))))
        w_err = AE_MISALIGN;
    end
  end

  assign M_EXC_AdEL = M_MemRead  && (w_err != AE_NONE) && !M_Flush;
  assign M_EXC_AdES = M_MemWrite && (w_err != AE_NONE) && !M_Flush;
  assign w_issue    = w_access && (w_err == AE_NONE) && !M_Flush && !(w_sc && !w_sc_ok);
  assign w_sc_fail  = w_sc && (w_err == AE_NONE) && !M_Flush && !w_sc_ok && (r_state == IDLE);

  load_store_align u_align (
    .i_byte     (M_MemByte),
    .i_half     (M_MemHalf),
    .i_left     (M_Left),
    .i_right    (M_Right),
    .i_sign_ext (M_MemSignExtend),
    .i_k        (w_k),
    .i_rt       (M_ReadData2),
    .i_mem      (dmem.DataMem_In),
    .o_store_dat(w_st_dat),
    .o_store_we (w_st_we),
    .o_load_dat (w_ld_dat)
  );

  // WAIT replays the captured request so a late flush cannot abort the bus cycle
  always_comb begin
    w_rd = 1'b0;
    w_we = BE_NONE;
    if (!reset) begin
      case (r_state)
        IDLE: if (w_issue) begin
          w_rd = M_MemRead;
          w_we = M_MemWrite ? w_st_we : BE_NONE;
        end
        WAIT: begin
          w_rd = r_rd;
          w_we = r_we;
        end
        default: ;
      endcase
    end
  end

  assign w_req     = w_rd || (w_we != BE_NONE);
  assign w_done    = w_req && dmem.DataMem_Ready;
  assign w_discard = (r_state == WAIT) && (M_Flush || r_flushed);
  assign w_result  = w_sc ? {31'b0, w_sc_ok} : w_ld_dat;

  assign dmem.DataMem_Read    = w_rd;
  assign dmem.DataMem_Write   = w_we;
  assign dmem.DataMem_Address = M_ALU_Result[31:2];
  assign dmem.DataMem_Out     = w_st_dat;
  assign M_Stall              = w_req && !dmem.DataMem_Ready;
  assign M_ReadData           = (r_state == HOLD) ? r_latch : w_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_rd      <= 1'b0;
      r_we      <= BE_NONE;
      r_flushed <= 1'b0;
      r_atomic  <= 1'b0;
      r_lladdr  <= '0;
      r_latch   <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_issue && !dmem.DataMem_Ready) begin
          r_state   <= WAIT;
          r_rd      <= w_rd;
          r_we      <= w_we;
          r_flushed <= 1'b0;
        end
        WAIT: begin
          if (M_Flush) r_flushed <= 1'b1;
          if (dmem.DataMem_Ready) begin
            r_rd    <= 1'b0;
            r_we    <= BE_NONE;
            r_latch <= w_result;
            r_state <= Pipe_Stall ? HOLD : IDLE;
          end
        end
        HOLD: if (!Pipe_Stall) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_done && !w_discard) begin
        if (w_ll) begin
          r_atomic <= 1'b1;
          r_lladdr <= M_ALU_Result[31:2];
        end else if (w_sc) begin
          r_atomic <= 1'b0;
        end
      end
      if (w_sc_fail) r_atomic <= 1'b0;
      if (Eret)      r_atomic <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed bench for data_mem_interface with a memory responder and a result scoreboard.
module tb_data_mem_interface;

  logic        clock = 1'b0;
  logic        reset;
  logic        M_MemRead, M_MemWrite, M_MemByte, M_MemHalf, M_MemSignExtend;
  logic        M_Left, M_Right, M_LLSC, M_ReverseEndian, M_KernelMode;
  logic [31:0] M_ALU_Result, M_ReadData2;
  logic        M_Flush, Pipe_Stall, Eret;
  logic [31:0] M_ReadData;
  logic        M_Stall, M_EXC_AdEL, M_EXC_AdES;

  data_mem_interface_if dmem();

  data_mem_interface dut (
    .clock          (clock),
    .reset          (reset),
    .M_MemRead      (M_MemRead),
    .M_MemWrite     (M_MemWrite),
    .M_MemByte      (M_MemByte),
    .M_MemHalf      (M_MemHalf),
    .M_MemSignExtend(M_MemSignExtend),
    .M_Left         (M_Left),
    .M_Right        (M_Right),
    .M_LLSC         (M_LLSC),
    .M_ReverseEndian(M_ReverseEndian),
    .M_KernelMode   (M_KernelMode),
    .M_ALU_Result   (M_ALU_Result),
    .M_ReadData2    (M_ReadData2),
    .M_Flush        (M_Flush),
    .Pipe_Stall     (Pipe_Stall),
    .Eret           (Eret),
    .dmem           (dmem),
    .M_ReadData     (M_ReadData),
    .M_Stall        (M_Stall),
    .M_EXC_AdEL     (M_EXC_AdEL),
    .M_EXC_AdES     (M_EXC_AdES)
  );

  always #5 clock = ~clock;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_sb(input string tag);
    if (sb_q.size() == 0) chk({tag, "/sb_empty"}, 32'd1, 32'd0);
    else chk(tag, M_ReadData, sb_q.pop_front());
  endtask

  task automatic clr();
    M_MemRead = 0; M_MemWrite = 0; M_MemByte = 0; M_MemHalf = 0; M_MemSignExtend = 0;
    M_Left = 0; M_Right = 0; M_LLSC = 0; M_ReverseEndian = 0; M_KernelMode = 1;
    M_ALU_Result = 0; M_ReadData2 = 0; M_Flush = 0; Pipe_Stall = 0; Eret = 0;
    dmem.DataMem_Ready = 0; dmem.DataMem_In = 0;
  endtask

  task automatic set_acc(input logic rd, input logic wr, input logic by, input logic hf,
                         input logic sx, input logic lf, input logic rg, input logic llsc,
                         input logic [31:0] addr, input logic [31:0] rt);
    M_MemRead = rd; M_MemWrite = wr; M_MemByte = by; M_MemHalf = hf; M_MemSignExtend = sx;
    M_Left = lf; M_Right = rg; M_LLSC = llsc; M_ALU_Result = addr; M_ReadData2 = rt;
  endtask

  // Memory answers after n_wait cycles; request and stall are checked every cycle.
  task automatic run(input string tag, input int n_wait, input logic [31:0] mem,
                     input logic [3:0] exp_we, input logic [31:0] exp_out, input logic has_rd);
    for (int c = 0; c <= n_wait; c++) begin
      dmem.DataMem_Ready = (c == n_wait);
      dmem.DataMem_In    = (c == n_wait) ? mem : 32'h0BAD0BAD;
      #1;
      chk({tag, "/stall"}, 32'(M_Stall), 32'(c != n_wait));
      chk({tag, "/we"}, 32'(dmem.DataMem_Write), 32'(exp_we));
      chk({tag, "/rd"}, 32'(dmem.DataMem_Read), 32'(exp_we == 4'b0000));
      chk({tag, "/addr"}, 32'(dmem.DataMem_Address), 32'(M_ALU_Result[31:2]));
      if (exp_we != 4'b0000) chk({tag, "/out"}, dmem.DataMem_Out, exp_out);
      if (c == n_wait && has_rd) chk_sb({tag, "/data"});
      @(negedge clock);
    end
    clr();
  endtask

  task automatic no_req(input string tag, input logic chk_rd, input logic adel, input logic ades);
    #1;
    chk({tag, "/rd"}, 32'(dmem.DataMem_Read), 32'd0);
    chk({tag, "/we"}, 32'(dmem.DataMem_Write), 32'd0);
    chk({tag, "/stall"}, 32'(M_Stall), 32'd0);
    chk({tag, "/adel"}, 32'(M_EXC_AdEL), 32'(adel));
    chk({tag, "/ades"}, 32'(M_EXC_AdES), 32'(ades));
    if (chk_rd) chk_sb({tag, "/data"});
    @(negedge clock);
    clr();
  endtask

  initial begin
    clr();
    reset = 1'b1;
    M_MemRead = 1; M_ALU_Result = 32'h100;
    #2;
    chk("reset/rd", 32'(dmem.DataMem_Read), 32'd0);
    chk("reset/we", 32'(dmem.DataMem_Write), 32'd0);
    chk("reset/stall", 32'(M_Stall), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    clr();
    @(negedge clock);

    set_acc(0, 1, 1, 0, 0, 0, 0, 0, 32'h1001, 32'h000000AB);
    run("sb", 0, 32'h0, 4'b0100, 32'hABABABAB, 0);

    set_acc(1, 0, 1, 0, 1, 0, 0, 0, 32'h1003, 32'h0);
    sb_q.push_back(32'hFFFFFFF0);
    run("lb", 3, 32'h123456F0, 4'b0000, 32'h0, 1);

    set_acc(1, 0, 1, 0, 0, 0, 0, 0, 32'h1000, 32'h0);
    M_ReverseEndian = 1;
    sb_q.push_back(32'h000000F0);
    run("lbu_rev", 1, 32'h123456F0, 4'b0000, 32'h0, 1);

    set_acc(1, 0, 0, 0, 0, 1, 0, 0, 32'h2002, 32'hAABBCCDD);
    sb_q.push_back(32'h3344CCDD);
    run("lwl", 1, 32'h11223344, 4'b0000, 32'h0, 1);

    set_acc(0, 1, 0, 0, 0, 0, 1, 0, 32'h2002, 32'hAABBCCDD);
    run("swr", 2, 32'h0, 4'b1110, 32'hBBCCDD00, 0);

    set_acc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 32'h0);
    sb_q.push_back(32'h12345678);
    run("ll", 1, 32'h12345678, 4'b0000, 32'h0, 1);
    set_acc(0, 1, 0, 0, 0, 0, 0, 1, 32'h3000, 32'hCAFEF00D);
    sb_q.push_back(32'h1);
    run("sc_ok", 0, 32'h0, 4'b1111, 32'hCAFEF00D, 1);
    set_acc(0, 1, 0, 0, 0, 0, 0, 1, 32'h3000, 32'hCAFEF00D);
    sb_q.push_back(32'h0);
    no_req("sc_again", 1, 0, 0);

    set_acc(1, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 32'h0);
    sb_q.push_back(32'h55AA55AA);
    run("ll2", 0, 32'h55AA55AA, 4'b0000, 32'h0, 1);
    Eret = 1;
    @(negedge clock);
    Eret = 0;
    set_acc(0, 1, 0, 0, 0, 0, 0, 1, 32'h3000, 32'h1);
    sb_q.push_back(32'h0);
    no_req("sc_eret", 1, 0, 0);

    set_acc(1, 0, 0, 0, 0, 0, 0, 0, 32'h3001, 32'h0);
    no_req("adel", 0, 1, 0);
    set_acc(0, 1, 0, 0, 0, 0, 0, 0, 32'h80000000, 32'h0);
    M_KernelMode = 0;
    no_req("ades", 0, 0, 1);
    set_acc(1, 0, 0, 0, 0, 0, 0, 0, 32'h3001, 32'h0);
    M_Flush = 1;
    no_req("adel_flush", 0, 0, 0);
    set_acc(0, 1, 0, 0, 0, 0, 0, 0, 32'h80000000, 32'h0);
    M_KernelMode = 0; M_Flush = 1;
    no_req("ades_flush", 0, 0, 0);

    // Ready lands while the pipe is stalled elsewhere: result must come from the latch
    set_acc(1, 0, 0, 0, 0, 0, 0, 0, 32'h4000, 32'h0);
    sb_q.push_back(32'hDEADBEEF);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hold/stall_pre", 32'(M_Stall), 32'd1);
      @(negedge clock);
    end
    dmem.DataMem_Ready = 1; dmem.DataMem_In = 32'hDEADBEEF; Pipe_Stall = 1;
    #1;
    chk("hold/stall_rdy", 32'(M_Stall), 32'd0);
    chk_sb("hold/data_rdy");
    @(negedge clock);
    dmem.DataMem_Ready = 0; dmem.DataMem_In = 32'h0BAD0BAD;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("hold/rd", 32'(dmem.DataMem_Read), 32'd0);
      chk("hold/stall", 32'(M_Stall), 32'd0);
      chk("hold/data", M_ReadData, 32'hDEADBEEF);
      @(negedge clock);
    end
    clr();
    #1;
    chk("hold/data_last", M_ReadData, 32'hDEADBEEF);
    chk("hold/rd_last", 32'(dmem.DataMem_Read), 32'd0);
    @(negedge clock);

    set_acc(1, 0, 0, 0, 0, 0, 0, 0, 32'h5000, 32'h0);
    #1;
    chk("rstwait/rd_issue", 32'(dmem.DataMem_Read), 32'd1);
    @(negedge clock);
    #1;
    chk("rstwait/rd_wait", 32'(dmem.DataMem_Read), 32'd1);
    chk("rstwait/stall_wait", 32'(M_Stall), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstwait/rd", 32'(dmem.DataMem_Read), 32'd0);
    chk("rstwait/stall", 32'(M_Stall), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    clr();
    @(negedge clock);
    #1;
    chk("rstwait/rd_after", 32'(dmem.DataMem_Read), 32'd0);
    chk("sb/leftover", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
